// File: rtl/overlay_pixel_gen.sv
// overlay_pixel_gen: background/glyph ROM addressing, latency-aligned pixel
// composition and a hover/press/release button FSM for overlay screens.
module overlay_pixel_gen #(
    parameter int          NUM_DIGITS  = 4,
    parameter int          DIGIT_SIZE  = 52,
    parameter int          ORIGIN_X    = 133,
    parameter int          ORIGIN_Y    = 210,
    parameter int          DIGIT_PITCH = 53,
    parameter int          GAP_AFTER   = 2,
    parameter int          GAP_EXTRA   = 3,
    parameter int          ROM_LATENCY = 1,
    parameter logic [11:0] C_TOUCH     = 12'h32E,
    parameter logic [11:0] C_CLICK     = 12'hDD2
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    input  logic                  active,
    input  logic                  mouse_left,
    input  logic                  mouse_on_button,
    input  logic [1:0]            bg_data,
    input  logic                  digit_data,
    output logic [16:0]           bg_addr,
    output logic [11:0]           digit_addr,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [11:0]           pixel_out,
    output logic [1:0]            button_state,
    output logic                  click
);
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    typedef enum logic [1:0] {IDLE = 2'd0, HOVER = 2'd1, PRESSED = 2'd2} state_t;

    function automatic int slot_x(input int p);
        return ORIGIN_X + p * DIGIT_PITCH + (p >= GAP_AFTER ? GAP_EXTRA : 0);
    endfunction

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic        w_visible;
    logic        w_hit_row;
    logic        w_hit;
    logic [2:0]  r_flags_d [ROM_LATENCY];
    logic        w_act_d;
    logic        w_vis_d;
    logic        w_hit_d;
    logic [11:0] w_btn_color;
    logic [11:0] w_pixel;
    logic [11:0] r_pixel;
    state_t      r_state;
    logic        r_click;

    // Reset asserts asynchronously but releases in step with clka
    always_ff @(posedge clka or negedge rst_n)
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};

    assign w_rst_n   = r_rst_sync[1];
    assign w_visible = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    assign w_hit_row = (int'(v_cnt) >= ORIGIN_Y) && (int'(v_cnt) < ORIGIN_Y + DIGIT_SIZE);
    assign bg_addr   = w_visible ? 17'(h_cnt >> 1) + 17'(v_cnt >> 1) * 17'd320 : 17'd0;

    // Scanning from the rightmost slot down lets the lowest position win overlaps
    always_comb begin
        digit_sel  = '0;
        digit_addr = '0;
        w_hit      = 1'b0;
        for (int p = NUM_DIGITS - 1; p >= 0; p--)
            if (w_visible && w_hit_row && int'(h_cnt) >= slot_x(p) &&
                int'(h_cnt) < slot_x(p) + DIGIT_SIZE) begin
                digit_sel                 = '0;
                digit_sel[NUM_DIGITS-1-p] = 1'b1;
                digit_addr = 12'((int'(v_cnt) - ORIGIN_Y) * DIGIT_SIZE + int'(h_cnt) - slot_x(p));
                w_hit      = 1'b1;
            end
    end

    always_ff @(posedge clka or negedge w_rst_n)
        if (!w_rst_n) begin
            for (int i = 0; i < ROM_LATENCY; i++) r_flags_d[i] <= '0;
        end else begin
            r_flags_d[0] <= {active, w_visible, w_hit};
            for (int i = 1; i < ROM_LATENCY; i++) r_flags_d[i] <= r_flags_d[i-1];
        end

    assign {w_act_d, w_vis_d, w_hit_d} = r_flags_d[ROM_LATENCY-1];
    assign w_btn_color = (r_state == HOVER)   ? C_TOUCH :
                         (r_state == PRESSED) ? C_CLICK : BLACK;
    assign w_pixel = !(w_act_d && w_vis_d) ? BLACK :
                     w_hit_d               ? (digit_data ? WHITE : BLACK) :
                     (bg_data == 2'd2)     ? w_btn_color :
                     (bg_data == 2'd0)     ? BLACK : WHITE;

    always_ff @(posedge clka or negedge w_rst_n)
        if (!w_rst_n) r_pixel <= BLACK;
        else          r_pixel <= w_pixel;

    always_ff @(posedge clka or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_click <= 1'b0;
        end else begin
            r_click <= 1'b0;
            if (!active) r_state <= IDLE;
            else
                case (r_state)
                    IDLE:    if (mouse_on_button && !mouse_left) r_state <= HOVER;
                    HOVER:   if (!mouse_on_button) r_state <= IDLE;
                             else if (mouse_left)  r_state <= PRESSED;
                    PRESSED: if (!mouse_on_button) r_state <= IDLE;
                             else if (!mouse_left) begin
                                 r_state <= HOVER;
                                 r_click <= 1'b1;
                             end
                    default: r_state <= IDLE;
                endcase
        end

    assign pixel_out    = r_pixel;
    assign button_state = r_state;
    assign click        = r_click;
endmodule

// File: tb/tb_overlay_pixel_gen.sv
// tb_overlay_pixel_gen: scoreboard plus direct checks of overlay_pixel_gen at latency 1 and 3
module tb_overlay_pixel_gen;
  localparam int K_PIX = 0, K_STATE = 1, K_CLICK = 2, K_SEL = 3, K_DADDR = 4, K_BGADDR = 5, K_PIX3 = 6;
  typedef struct {int due; int kind; int exp;} exp_t;
  logic clka = 1'b0;
  logic rst_n;
  logic [9:0] h_cnt, v_cnt;
  logic active, mouse_left, mouse_on_button, digit_data;
  logic [1:0] bg_data1, bg_data3;
  logic [16:0] bg_addr1, bg_addr3;
  logic [11:0] digit_addr1, digit_addr3, pixel1, pixel3;
  logic [3:0] sel1, sel3;
  logic [1:0] state1, state3;
  logic click1, click3;
  logic [1:0] rom3 [3];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];
  string kname [7] = '{"pixel", "state", "click", "digit_sel", "digit_addr", "bg_addr", "pixel_l3"};
  overlay_pixel_gen u_dut1 (
    .clka(clka), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .mouse_left(mouse_left), .mouse_on_button(mouse_on_button), .bg_data(bg_data1),
    .digit_data(digit_data), .bg_addr(bg_addr1), .digit_addr(digit_addr1), .digit_sel(sel1),
    .pixel_out(pixel1), .button_state(state1), .click(click1));
  overlay_pixel_gen #(.ROM_LATENCY(3)) u_dut3 (
    .clka(clka), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .mouse_left(mouse_left), .mouse_on_button(mouse_on_button), .bg_data(bg_data3),
    .digit_data(digit_data), .bg_addr(bg_addr3), .digit_addr(digit_addr3), .digit_sel(sel3),
    .pixel_out(pixel3), .button_state(state3), .click(click3));
  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;
  always @(posedge clka) begin
    rom3[0] <= bg_addr3[1:0];
    rom3[1] <= rom3[0];
    rom3[2] <= rom3[1];
  end
  assign bg_data3 = rom3[2];
  function automatic int actual(input int k);
    case (k)
      K_PIX:    return int'(pixel1);
      K_STATE:  return int'(state1);
      K_CLICK:  return int'(click1);
      K_SEL:    return int'(sel1);
      K_DADDR:  return int'(digit_addr1);
      K_BGADDR: return int'(bg_addr1);
      default:  return int'(pixel3);
    endcase
  endfunction
  always @(negedge clka)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        n_checks++;
        if (actual(sb[i].kind) == sb[i].exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h want %0h", kname[sb[i].kind], cyc,
                      actual(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
  task automatic push(input int due, input int kind, input int exp);
    sb.push_back('{due, kind, exp});
  endtask
  task automatic step();
    @(posedge clka);
    #1;
  endtask
  task automatic vec(input int h, input int v, input logic a, input logic on, input logic l,
                     input logic [1:0] bg, input logic dd, input int px, input int st,
                     input logic ck, input int sel, input int da, input int ba);
    step();
    h_cnt = 10'(h); v_cnt = 10'(v); active = a; mouse_on_button = on; mouse_left = l;
    bg_data1 = bg; digit_data = dd;
    push(cyc, K_SEL, sel);
    push(cyc, K_DADDR, da);
    push(cyc, K_BGADDR, ba);
    push(cyc + 1, K_STATE, st);
    push(cyc + 1, K_CLICK, int'(ck));
    push(cyc + 2, K_STATE, st);
    push(cyc + 2, K_CLICK, 0);
    push(cyc + 2, K_PIX, px);
    repeat (2) @(posedge clka);
  endtask
  initial begin
    rst_n = 1'b1;
    h_cnt = '0; v_cnt = '0; active = 1'b1; mouse_on_button = 1'b0; mouse_left = 1'b0;
    bg_data1 = 2'd1; digit_data = 1'b0;
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      push(cyc, K_PIX, 0); push(cyc, K_STATE, 0); push(cyc, K_CLICK, 0); push(cyc, K_PIX3, 0);
    end
    n_checks++;
    if (pixel1 === 12'h000) n_pass++;
    else $display("FAIL reset pixel1 %0h", pixel1);
    n_checks++;
    if (state1 === 2'd0) n_pass++;
    else $display("FAIL reset state1 %0d", state1);
    n_checks++;
    if (click1 === 1'b0) n_pass++;
    else $display("FAIL reset click1 %0b", click1);
    n_checks++;
    if (pixel3 === 12'h000) n_pass++;
    else $display("FAIL reset pixel3 %0h", pixel3);
    rst_n = 1'b1;
    step();
    step();
    vec(0,   0,   1, 0, 0, 1, 0, 'hFFF, 0, 0, 0, 0, 0);
    vec(639, 479, 1, 0, 0, 1, 0, 'hFFF, 0, 0, 0, 0, 76799);
    vec(640, 0,   1, 0, 0, 1, 0, 'h000, 0, 0, 0, 0, 0);
    vec(0,   480, 1, 0, 0, 1, 0, 'h000, 0, 0, 0, 0, 0);
    vec(184, 210, 1, 0, 0, 0, 1, 'hFFF, 0, 0, 'b1000, 51, 33692);
    vec(185, 210, 1, 0, 0, 0, 1, 'h000, 0, 0, 0, 0, 33692);
    vec(186, 210, 1, 0, 0, 1, 0, 'h000, 0, 0, 'b0100, 0, 33693);
    vec(241, 211, 1, 0, 0, 3, 1, 'hFFF, 0, 0, 0, 0, 33720);
    vec(242, 211, 1, 0, 0, 0, 1, 'hFFF, 0, 0, 'b0010, 52, 33721);
    vec(346, 261, 1, 0, 0, 0, 1, 'hFFF, 0, 0, 'b0001, 2703, 41773);
    vec(300, 262, 1, 0, 0, 1, 1, 'hFFF, 0, 0, 0, 0, 42070);
    vec(100, 100, 0, 0, 0, 1, 0, 'h000, 0, 0, 0, 0, 16050);
    active = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      h_cnt = 10'(2 * k); v_cnt = 10'd2;
      push(cyc + 4, K_PIX3, (k % 2 == 1) ? 'hFFF : 'h000);
    end
    repeat (5) step();
    vec(10, 10, 1, 0, 0, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 0, 2, 0, 'h32E, 1, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'hDD2, 2, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 0, 2, 0, 'h32E, 1, 1, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'hDD2, 2, 0, 0, 0, 1605);
    vec(10, 10, 1, 0, 1, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 0, 0, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 0, 1, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 0, 2, 0, 'h32E, 1, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'hDD2, 2, 0, 0, 0, 1605);
    vec(10, 10, 0, 1, 1, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 0, 2, 0, 'h32E, 1, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'hDD2, 2, 0, 0, 0, 1605);
    vec(10, 10, 1, 0, 0, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 0, 2, 0, 'h32E, 1, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 1, 2, 0, 'hDD2, 2, 0, 0, 0, 1605);
    step();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(cyc, K_STATE, 0); push(cyc, K_CLICK, 0); push(cyc, K_PIX, 0);
      step();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(cyc, K_STATE, 0); push(cyc, K_CLICK, 0);
      step();
    end
    vec(10, 10, 1, 1, 1, 2, 0, 'h000, 0, 0, 0, 0, 1605);
    vec(10, 10, 1, 1, 0, 2, 0, 'h32E, 1, 0, 0, 0, 1605);
    repeat (4) step();
    n_checks++;
    if (state1 === 2'd1) n_pass++;
    else $display("FAIL final state1 %0d", state1);
    n_checks++;
    if (click1 === 1'b0) n_pass++;
    else $display("FAIL final click1 %0b", click1);
    n_checks++;
    if (pixel1 === 12'h32E) n_pass++;
    else $display("FAIL final pixel1 %0h", pixel1);
    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s due %0d: got none want %0h", kname[sb[i].kind], sb[i].due, sb[i].exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
